// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// MDU_MADD_EN adds the multiply-accumulate encodings, which widens the op field to 4 bits.
package mdu_pkg;

`ifdef MDU_MADD_EN
    localparam int MDOP_W = 4;
`else
    localparam int MDOP_W = 3;
`endif

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [MDOP_W-1:0] {
        OP_MULT  = MDOP_W'(0),
        OP_MULTU = MDOP_W'(1),
        OP_DIV   = MDOP_W'(2),
        OP_DIVU  = MDOP_W'(3),
        OP_MTHI  = MDOP_W'(4),
        OP_MTLO  = MDOP_W'(5)
`ifdef MDU_MADD_EN
        ,
        OP_MADD  = MDOP_W'(6),
        OP_MADDU = MDOP_W'(7),
        OP_MSUB  = MDOP_W'(8),
        OP_MSUBU = MDOP_W'(9)
`endif
    } mdop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    function automatic logic is_signed_op(input mdop_e op);
        case (op)
            OP_MULT, OP_DIV: return 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_divcore.sv
// Combinational 32-bit divider: quotient truncates toward zero, remainder takes
// the dividend's sign. A zero divisor is flagged and yields zero outputs.
module md_divcore (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign a_neg    = is_signed & a[31];
    assign b_neg    = is_signed & b[31];
    assign a_mag    = a_neg ? (~a + 32'd1) : a;
    assign b_mag    = b_neg ? (~b + 32'd1) : b;
    assign div_zero = (b == 32'd0);

    // 0x80000000 / -1 falls out naturally: magnitude 2^31 negates back onto itself.
    assign q_mag = div_zero ? 32'd0 : (a_mag / b_mag);
    assign r_mag = div_zero ? 32'd0 : (a_mag % b_mag);

    assign quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem  = a_neg ? (~r_mag + 32'd1) : r_mag;

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning architectural HI/LO.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo}).
module md_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MDOP_W-1:0] mdop,
    input  logic [31:0]       rs_out,
    input  logic [31:0]       rt_out,
    output logic              busy,
    output logic              done,
    output logic [31:0]       hi,
    output logic [31:0]       lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    mdop_e            op_reg;
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             op_signed;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [63:0]      prod;
    logic [31:0]      div_quot;
    logic [31:0]      div_rem;
    logic             div_zero;
    logic [63:0]      res_next;
    mdop_e            mdop_in;

    assign mdop_in   = mdop_e'(mdop);
    assign op_signed = is_signed_op(op_reg);

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
    assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};
    assign prod   = op_signed ? prod_s : prod_u;

    md_divcore u_divcore (
        .a        (a_reg),
        .b        (b_reg),
        .is_signed(op_signed),
        .quot     (div_quot),
        .rem      (div_rem),
        .div_zero (div_zero)
    );

    always_comb begin
        res_next = {hi_reg, lo_reg};
        case (op_reg)
            OP_MULT, OP_MULTU: res_next = prod;
            OP_DIV, OP_DIVU: begin
                if (!div_zero) res_next = {div_rem, div_quot};
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: res_next = {hi_reg, lo_reg} + prod;
            OP_MSUB, OP_MSUBU: res_next = {hi_reg, lo_reg} - prod;
`endif
            default: res_next = {hi_reg, lo_reg};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= OP_MULT;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        case (mdop_in)
`ifdef MDU_MADD_EN
                            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
`else
                            OP_MULT, OP_MULTU: begin
`endif
                                op_reg    <= mdop_in;
                                a_reg     <= rs_out;
                                b_reg     <= rt_out;
                                cnt_reg   <= CNT_W'(MULT_CYCLES);
                                busy_reg  <= 1'b1;
                                state_reg <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_reg    <= mdop_in;
                                a_reg     <= rs_out;
                                b_reg     <= rt_out;
                                cnt_reg   <= CNT_W'(DIV_CYCLES);
                                busy_reg  <= 1'b1;
                                state_reg <= ST_DIV;
                            end
                            OP_MTHI: hi_reg <= rs_out;
                            OP_MTLO: lo_reg <= rs_out;
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        {hi_reg, lo_reg} <= res_next;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default build, MDU_MADD_EN undefined).
module tb_md_unit;
    import mdu_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [MDOP_W-1:0] mdop = '0;
    logic [31:0]       rs_out = '0;
    logic [31:0]       rt_out = '0;
    logic              busy;
    logic              done;
    logic [31:0]       hi;
    logic [31:0]       lo;

    int total = 0;
    int bad   = 0;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .rs_out(rs_out),
        .rt_out(rt_out),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // The bench must never issue a request while the unit is busy.
    always @(posedge clk) begin
        if (reset && start && busy) begin
            total++;
            assert (1'b0) else begin
                bad++;
                $error("FAIL protocol start_while_busy obs=1 exp=0");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Issue a multi-cycle op; check busy/done timing, hold of old HI/LO, and the result.
    task automatic run_op(input string tag, input mdop_e op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] ph, input logic [31:0] pl,
                          input logic [31:0] eh, input logic [31:0] el);
        start  = 1'b1;
        mdop   = op;
        rs_out = a;
        rt_out = b;
        tick();
        start  = 1'b0;
        rs_out = 32'h5A5A_1234;
        rt_out = 32'h0000_0007;
        chk({tag, "_busy_accept"}, 32'(busy), 32'd1);
        chk({tag, "_done_accept"}, 32'(done), 32'd0);
        for (int k = 1; k < n; k++) begin
            tick();
            chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            chk({tag, "_hi_hold"}, hi, ph);
            chk({tag, "_lo_hold"}, lo, pl);
        end
        tick();
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_done_end"}, 32'(done), 32'd1);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        $display("txn %s a=%h b=%h hi=%h lo=%h", tag, a, b, hi, lo);
    endtask

    initial begin
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        #11 reset = 1'b1;
        tick();

        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'd0, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFA);
        tick();
        chk("mult_done_clear", 32'(done), 32'd0);

        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'h0000_0001, 32'h7FFF_FFFC, 32'h0000_0000, 32'h8000_0000);

        start = 1'b1; mdop = OP_MTHI; rs_out = 32'h1234_5678;
        tick();
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", 32'(busy), 32'd0);
        mdop = OP_MTLO; rs_out = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_hi", hi, 32'h1234_5678);
        chk("mtlo_busy", 32'(busy), 32'd0);
        $display("txn mthi/mtlo hi=%h lo=%h", hi, lo);

        start = 1'b1; mdop = MDOP_W'(6); rs_out = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        chk("undef_busy", 32'(busy), 32'd0);
        chk("undef_hi", hi, 32'h1234_5678);
        chk("undef_lo", lo, 32'h9ABC_DEF0);
        $display("txn undefined op hi=%h lo=%h", hi, lo);

        start = 1'b1; mdop = OP_MTHI; rs_out = 32'hAAAA_5555;
        tick();
        mdop = OP_MTLO;
        tick();
        start = 1'b0;
        run_op("div0", OP_DIV, 32'h0000_0064, 32'd0, 10,
               32'hAAAA_5555, 32'hAAAA_5555, 32'hAAAA_5555, 32'hAAAA_5555);
        run_op("divu0", OP_DIVU, 32'hFFFF_0000, 32'd0, 10,
               32'hAAAA_5555, 32'hAAAA_5555, 32'hAAAA_5555, 32'hAAAA_5555);

        start = 1'b1; mdop = OP_DIV; rs_out = 32'd100; rt_out = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_busy_pre", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        $display("txn reset abort busy=%b hi=%h lo=%h", busy, hi, lo);
        #2 reset = 1'b1;
        tick();
        chk("post_abort_busy", 32'(busy), 32'd0);

        run_op("mult_after", OP_MULT, 32'd7, 32'd6, 5, 32'd0, 32'd0,
               32'd0, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
